// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Purpose  : Instruction-memory request/ready handshake bundle between the
//            fetch stage (master) and the instruction memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : RV32I instruction-fetch stage. Owns the PC, drives a variable
//            latency imem request/ready handshake and produces IF/ID.
//            Honours load-use stalls (one-entry hold buffer) and
//            flush/redirect, discarding stale responses after a redirect.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  wire logic            clk,
  input  wire logic            rst,          // asynchronous, active-low
  input  wire logic            stall_if,
  input  wire logic            flush,
  input  wire logic [XLEN-1:0] redirect_pc,
  fetch_stage_if.master        imem,
  output logic                 if_id_valid,
  output logic [XLEN-1:0]      if_id_pc,
  output logic [31:0]          if_id_instr
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_KILL  = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            if_id_valid_q, if_id_valid_d;
  logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
  logic [31:0]     if_id_instr_q, if_id_instr_d;
  logic            hold_valid_q, hold_valid_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [31:0]     hold_instr_q, hold_instr_d;

  logic            req;
  logic            xfer;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_aligned;

  // Request generation: gated by reset so nothing is issued while held in reset.
  always_comb begin
    req              = rst && ((state_q == S_FETCH) || (state_q == S_WAIT)) && !hold_valid_q;
    xfer             = req && imem.imem_ready;
    pc_plus4         = pc_q + PC_STEP;
    redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;

  assign if_id_valid = if_id_valid_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;

  // Next-state, PC, IF/ID and hold-buffer update; flush outranks stall and transfer.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    hold_valid_d  = hold_valid_q;
    hold_pc_d     = hold_pc_q;
    hold_instr_d  = hold_instr_q;

    if (flush) begin
      if_id_valid_d = 1'b0;
      if_id_pc_d    = '0;
      if_id_instr_d = NOP_INSTR;
      hold_valid_d  = 1'b0;
      pc_d          = redirect_aligned;
      // A request left outstanding (newly or from an earlier kill) must drain first.
      if ((req && !imem.imem_ready) || (state_q == S_KILL && !imem.imem_ready))
        state_d = S_KILL;
      else
        state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH, S_WAIT: begin
          if (xfer) begin
            pc_d = pc_plus4;
            if (stall_if) begin
              hold_valid_d = 1'b1;
              hold_pc_d    = pc_q;
              hold_instr_d = imem.imem_rdata;
              state_d      = S_HOLD;
            end else begin
              if_id_valid_d = 1'b1;
              if_id_pc_d    = pc_q;
              if_id_instr_d = imem.imem_rdata;
              state_d       = S_FETCH;
            end
          end else if (!stall_if) begin
            if_id_valid_d = 1'b0;
            if_id_pc_d    = '0;
            if_id_instr_d = NOP_INSTR;
            state_d       = S_WAIT;
          end
        end
        S_HOLD: begin
          if (!stall_if) begin
            if_id_valid_d = hold_valid_q;
            if_id_pc_d    = hold_pc_q;
            if_id_instr_d = hold_instr_q;
            hold_valid_d  = 1'b0;
            state_d       = S_FETCH;
          end
        end
        S_KILL: begin
          if (!stall_if) begin
            if_id_valid_d = 1'b0;
            if_id_pc_d    = '0;
            if_id_instr_d = NOP_INSTR;
          end
          // The stale response is dropped; fetching resumes on the next cycle.
          if (imem.imem_ready)
            state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
      hold_valid_q  <= 1'b0;
      hold_pc_q     <= '0;
      hold_instr_q  <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      hold_valid_q  <= hold_valid_d;
      hold_pc_q     <= hold_pc_d;
      hold_instr_q  <= hold_instr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage. Instruction memory
//            returns addr+0x100 (mem[i] = i*4+0x100) or a stale pattern.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
  localparam int          XLEN = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic            clk;
  logic            rst;
  logic            stall_if;
  logic            flush;
  logic [XLEN-1:0] redirect_pc;
  logic            ready_tb;
  logic            stale_tb;
  logic            if_id_valid;
  logic [XLEN-1:0] if_id_pc;
  logic [31:0]     if_id_instr;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  fetch_stage_if #(.XLEN(XLEN)) imem ();

  assign imem.imem_ready = ready_tb;
  assign imem.imem_rdata = stale_tb ? 32'hDEAD_BEEF : (imem.imem_addr + 32'h100);

  fetch_stage #(
    .XLEN      (XLEN),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_if    (stall_if),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .imem        (imem.master),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd1);
    chk({tag, "_pc"}, if_id_pc, pc);
    chk({tag, "_instr"}, if_id_instr, instr);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
    chk({tag, "_instr"}, if_id_instr, NOP);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; stall_if = 1'b0; flush = 1'b0; redirect_pc = '0;
    ready_tb = 1'b0; stale_tb = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
    chk("rst_addr", imem.imem_addr, 32'h0);
    chk_bubble("rst_ifid");
    chk("rst_ifid_pc", if_id_pc, 32'h0);

    // Release reset with a single-cycle memory
    ready_tb = 1'b1;
    rst      = 1'b1;
    #1;
    chk("req_after_rst", {31'd0, imem.imem_req}, 32'd1);
    tick(); chk_ifid("seq0", 32'h0, 32'h100); chk("seq0_addr", imem.imem_addr, 32'h4);
    tick(); chk_ifid("seq1", 32'h4, 32'h104); chk("seq1_addr", imem.imem_addr, 32'h8);

    // Memory not ready for 3 cycles at pc=8
    ready_tb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_addr", imem.imem_addr, 32'h8);
      chk("wait_req", {31'd0, imem.imem_req}, 32'd1);
      tick(); chk_bubble("wait_ifid");
    end
    ready_tb = 1'b1;
    chk("wait_addr4", imem.imem_addr, 32'h8);
    tick(); chk_ifid("wait_done", 32'h8, 32'h108); chk("wait_done_addr", imem.imem_addr, 32'hC);

    // Stall coincident with the transfer of pc=0xC
    stall_if = 1'b1;
    tick(); chk_ifid("hold1", 32'h8, 32'h108);
    chk("hold1_req", {31'd0, imem.imem_req}, 32'd0); chk("hold1_addr", imem.imem_addr, 32'h10);
    tick(); chk_ifid("hold2", 32'h8, 32'h108);
    chk("hold2_req", {31'd0, imem.imem_req}, 32'd0);
    stall_if = 1'b0;
    tick(); chk_ifid("release", 32'hC, 32'h10C);
    chk("release_req", {31'd0, imem.imem_req}, 32'd1); chk("release_addr", imem.imem_addr, 32'h10);
    tick(); chk_ifid("after_hold", 32'h10, 32'h110); chk("after_hold_addr", imem.imem_addr, 32'h14);

    // Flush with simultaneous stall
    flush = 1'b1; redirect_pc = 32'h40; stall_if = 1'b1;
    tick(); chk_bubble("flush40"); chk("flush40_addr", imem.imem_addr, 32'h40);
    chk("flush40_req", {31'd0, imem.imem_req}, 32'd1);
    flush = 1'b0; stall_if = 1'b0;
    tick(); chk_ifid("fetch40", 32'h40, 32'h140); chk("fetch40_addr", imem.imem_addr, 32'h44);

    // Flush while a request is pending, then a stale response
    ready_tb = 1'b0; flush = 1'b1; redirect_pc = 32'h80;
    tick(); chk_bubble("kill"); chk("kill_addr", imem.imem_addr, 32'h80);
    chk("kill_req", {31'd0, imem.imem_req}, 32'd0);
    flush = 1'b0; stale_tb = 1'b1; ready_tb = 1'b1;
    #1;
    chk("kill_req2", {31'd0, imem.imem_req}, 32'd0);
    tick(); chk_bubble("stale_drop"); chk("stale_req", {31'd0, imem.imem_req}, 32'd1);
    chk("stale_addr", imem.imem_addr, 32'h80);
    stale_tb = 1'b0;
    tick(); chk_ifid("fetch80", 32'h80, 32'h180); chk("fetch80_addr", imem.imem_addr, 32'h84);

    // Unaligned redirect near the top of memory, then PC wrap
    flush = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick(); chk_bubble("top_flush"); chk("top_addr", imem.imem_addr, 32'hFFFF_FFFC);
    flush = 1'b0;
    tick(); chk_ifid("top_fetch", 32'hFFFF_FFFC, 32'h0000_00FC);
    chk("wrap_addr", imem.imem_addr, 32'h0);
    tick(); chk_ifid("wrap_fetch", 32'h0, 32'h100); chk("wrap_next_addr", imem.imem_addr, 32'h4);

    // Asynchronous reset in the middle of a WAIT cycle
    ready_tb = 1'b0;
    tick(); chk_bubble("pre_rst_wait"); chk("pre_rst_addr", imem.imem_addr, 32'h4);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_addr", imem.imem_addr, 32'h0);
    chk("async_rst_req", {31'd0, imem.imem_req}, 32'd0);
    chk_bubble("async_rst_ifid");
    chk("async_rst_ifid_pc", if_id_pc, 32'h0);

    // Restart, then redirect to an unaligned address 0x7
    @(negedge clk);
    rst = 1'b1; ready_tb = 1'b1; flush = 1'b1; redirect_pc = 32'h7;
    tick(); chk_bubble("r7_flush"); chk("r7_addr", imem.imem_addr, 32'h4);
    flush = 1'b0;
    tick(); chk_ifid("r7_fetch", 32'h4, 32'h104); chk("r7_next_addr", imem.imem_addr, 32'h8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
